// File: rtl/iob_plic_claimer.sv
// iob_plic_claimer: hardware stand-in for a CPU interrupt service routine.
// It serves one PLIC target. On irq it reads the claim register, passes the
// claimed ID to a local handler, waits for done, then writes the ID back to
// complete the interrupt. A claim that returns ID 0 is counted as spurious.
module iob_plic_claimer #(
  parameter int          ADDR_W       = 16,
  parameter int          DATA_W       = 32,
  parameter int          ID_W         = 6,
  parameter int unsigned CLAIM_ADDR   = 0,
  parameter int          GUARD_CYCLES = 2,
  parameter int          CNT_W        = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                en_i,
  input  logic                irq_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                id_valid_o,
  output logic [ID_W-1:0]     id_o,
  input  logic                id_ready_i,
  input  logic                done_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    spurious_o
);

  // A guard of zero cycles still needs one cycle in GUARD to leave it.
  localparam int GUARD_LEN = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int GCNT_W    = (GUARD_LEN < 2) ? 1 : $clog2(GUARD_LEN);
  localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_LEN - 1);
  localparam logic [ADDR_W-1:0] CLAIM_A    = ADDR_W'(CLAIM_ADDR);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_DISPATCH = 3'd3,
    S_SERVICE  = 3'd4,
    S_WR_REQ   = 3'd5,
    S_GUARD    = 3'd6
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ID_W-1:0]   id_reg;
  logic [CNT_W-1:0]  spur_reg;
  logic [GCNT_W-1:0] guard_cnt_reg;
  logic              claim_zero;
  logic              guard_done;
  logic              unused_rdata;

  assign claim_zero = (iob_rdata_i[ID_W-1:0] == '0);
  assign guard_done = (guard_cnt_reg == GUARD_LAST);

  // Only the ID field of the claim word is meaningful.
  assign unused_rdata = ^iob_rdata_i[DATA_W-1:ID_W];

  // State register; reset aborts any sequence without issuing a complete.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (en_i && irq_i) state_next = S_RD_REQ;
      S_RD_REQ:   if (iob_ready_i) state_next = S_RD_WAIT;
      S_RD_WAIT:  if (iob_rvalid_i) state_next = claim_zero ? S_GUARD : S_DISPATCH;
      S_DISPATCH: if (id_ready_i) state_next = done_i ? S_WR_REQ : S_SERVICE;
      S_SERVICE:  if (done_i) state_next = S_WR_REQ;
      S_WR_REQ:   if (iob_ready_i) state_next = S_GUARD;
      S_GUARD:    if (guard_done) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Claimed ID, saturating spurious counter and guard timer.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      id_reg        <= '0;
      spur_reg      <= '0;
      guard_cnt_reg <= '0;
    end else begin
      if (state_reg == S_RD_WAIT && iob_rvalid_i) begin
        id_reg <= iob_rdata_i[ID_W-1:0];
        if (claim_zero && spur_reg != {CNT_W{1'b1}}) begin
          spur_reg <= spur_reg + 1'b1;
        end
      end
      if (state_reg != S_GUARD) begin
        guard_cnt_reg <= '0;
      end else if (!guard_done) begin
        guard_cnt_reg <= guard_cnt_reg + 1'b1;
      end
    end
  end

  // Bus and handler outputs decoded from the current state.
  always_comb begin
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    id_valid_o   = 1'b0;
    case (state_reg)
      S_RD_REQ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = CLAIM_A;
      end
      S_WR_REQ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = CLAIM_A;
        iob_wdata_o  = DATA_W'(id_reg);
        iob_wstrb_o  = '1;
      end
      S_DISPATCH: id_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o     = (state_reg != S_IDLE);
  assign id_o       = id_reg;
  assign spurious_o = spur_reg;

endmodule
